// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arm_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES           = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        abort;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush; push while full is accepted
// only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk1) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/prefetch stage: memory req/ack handshake, PC sequencing,
// redirect handling and a prefetch FIFO feeding decode.
module fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_abort,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  output logic                   inst_abort,
  input  logic                   branch_valid,
  input  logic [31:0]            branch_target,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc;
  logic [31:0]  stale_addr;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] occ_after_pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign inst_valid    = !fifo_empty;
  assign pop           = inst_valid && inst_ready && !branch_valid;
  assign occ_after_pop = fifo_count - {{(CW-1){1'b0}}, pop};
  assign wr_entry      = '{data: mem_rdata, pc: fetch_pc, abort: mem_abort};

  // NOTE: sequential state is written with <= only, so every process sees the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (branch_valid || (occ_after_pop < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (branch_valid)
          state_d = mem_ack ? REQ : DISCARD;
        else if (mem_ack)
          state_d = ((occ_after_pop + 1'b1) < DEPTH_C) ? REQ : IDLE;
      end
      DISCARD: begin
        if (mem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // The old request stays on the bus in DISCARD until memory answers it.
  always_comb begin
    mem_req  = (state_q != IDLE);
    mem_addr = (state_q == DISCARD) ? stale_addr : fetch_pc;
    push     = (state_q == REQ) && mem_ack && !branch_valid && (!fifo_full || pop);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_VECTOR;
      stale_addr <= RESET_VECTOR;
    end else begin
      if (branch_valid)  fetch_pc <= branch_target & ~32'd3;
      else if (push)     fetch_pc <= fetch_pc + 32'(WORD_BYTES);
      if ((state_q == REQ) && branch_valid && !mem_ack) stale_addr <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk1  (clk1),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (branch_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign inst_data  = fifo_empty ? 32'd0 : head.data;
  assign inst_pc    = fifo_empty ? 32'd0 : head.pc;
  assign inst_abort = fifo_empty ? 1'b0  : head.abort;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based stream model plus directed
// scenarios with hand-computed expectations.
module tb_fetch_unit;
  import arm_fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

  logic        clk1;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_abort;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_abort;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [$clog2(DEPTH):0] fifo_count;

  fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_abort     (mem_abort),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_abort    (inst_abort),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .fifo_count    (fifo_count)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int          n_pass = 0;
  int          n_total = 0;
  int          n_acks = 0;
  int          mem_lat = 0;
  logic        abort_en = 1'b0;
  logic [31:0] abort_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Memory: acks mem_lat cycles into each request; data is address ^ PAT.
  initial begin : responder
    logic prev_req;
    int   age;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mem_abort = 1'b0;
    prev_req  = 1'b0;
    age       = 0;
    forever begin
      @(posedge clk1);
      #1;
      if (!rst_n || !mem_req) begin
        age     = 0;
        mem_ack = 1'b0;
      end else begin
        if (prev_req && !mem_ack) age++;
        else age = 0;
        mem_ack = (age >= mem_lat);
      end
      prev_req  = rst_n && mem_req;
      mem_rdata = mem_addr ^ PAT;
      mem_abort = abort_en && (mem_addr == abort_addr);
    end
  end

  // Stream model: the FIFO is a queue of words fetched in program order since
  // the last redirect; a request outstanding at a redirect yields nothing.
  fetch_entry_t mq[$];
  logic [31:0]  m_next;
  logic [31:0]  m_stale_addr;
  logic         m_stale;
  logic         m_armed;

  always @(negedge clk1) begin
    if (!rst_n) begin
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_abort", {31'd0, inst_abort}, 32'd0);
      mq.delete();
      m_next  = 32'h0;
      m_stale = 1'b0;
      m_armed = 1'b0;
      n_acks  = 0;
    end else begin
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("inst_valid", {31'd0, inst_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        check("inst_pc", inst_pc, mq[0].pc);
        check("inst_data", inst_data, mq[0].data);
        check("inst_abort", {31'd0, inst_abort}, {31'd0, mq[0].abort});
      end
      if (!m_armed) begin
        check("mem_req_first", {31'd0, mem_req}, 32'd0);
        m_armed = 1'b1;
      end else begin
        check("mem_req", {31'd0, mem_req}, {31'd0, mq.size() < DEPTH});
      end
      if (mem_req) check("mem_addr", mem_addr, m_stale ? m_stale_addr : m_next);

      if (mem_req && mem_ack) n_acks++;
      if (branch_valid) begin
        mq.delete();
        if (mem_req && !mem_ack) begin
          if (!m_stale) m_stale_addr = m_next;
          m_stale = 1'b1;
        end else if (mem_req) begin
          m_stale = 1'b0;
        end
        m_next = branch_target & ~32'd3;
      end else begin
        if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
        if (mem_req && mem_ack) begin
          if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            mq.push_back('{data: m_next ^ PAT, pc: m_next,
                           abort: abort_en && (m_next == abort_addr)});
            m_next = m_next + 32'd4;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit found;
    inst_ready    = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    rst_n         = 1'b1;
    #1;

    // Zero-wait streaming from the reset vector.
    mem_lat = 0;
    do_reset();
    step();
    check("t1_req_rise", {31'd0, mem_req}, 32'd1);
    check("t1_addr0", mem_addr, 32'h0);
    check("t1_not_valid_yet", {31'd0, inst_valid}, 32'd0);
    step();
    check("t1_first_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_pc0", inst_pc, 32'h0);
    check("t1_data0", inst_data, 32'hA5A5_A5A5);
    check("t1_addr4", mem_addr, 32'h4);
    step();
    check("t1_pc4", inst_pc, 32'h4);
    check("t1_data4", inst_data, 32'hA5A5_A5A1);
    repeat (4) step();

    // Backpressure fills the FIFO, then draining resumes fetch at 0x10.
    inst_ready = 1'b0;
    do_reset();
    repeat (8) step();
    check("t2_count_full", 32'(fifo_count), 32'd4);
    check("t2_req_low", {31'd0, mem_req}, 32'd0);
    check("t2_four_acks", 32'(n_acks), 32'd4);
    check("t2_hold_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    check("t2_pop_pc4", inst_pc, 32'h4);
    check("t2_resume_req", {31'd0, mem_req}, 32'd1);
    check("t2_resume_addr", mem_addr, 32'h10);
    check("t2_count3", 32'(fifo_count), 32'd3);
    repeat (6) step();

    // Redirect during a slow request: old response discarded.
    mem_lat = 3;
    do_reset();
    step();
    step();
    branch_valid  = 1'b1;
    branch_target = 32'h103;
    step();
    branch_valid = 1'b0;
    check("t3_discard_req", {31'd0, mem_req}, 32'd1);
    check("t3_discard_addr", mem_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 32'h100) found = 1'b1;
    end
    check("t3_new_addr_seen", {31'd0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (inst_valid) found = 1'b1;
    end
    check("t3_valid_seen", {31'd0, found}, 32'd1);
    check("t3_first_pc", inst_pc, 32'h100);
    repeat (6) step();

    // Redirect coinciding with ack and pop while nearly full.
    mem_lat    = 0;
    inst_ready = 1'b0;
    do_reset();
    repeat (8) step();
    inst_ready = 1'b1;
    step();
    branch_valid  = 1'b1;
    branch_target = 32'h200;
    step();
    branch_valid = 1'b0;
    check("t4_flushed_count", 32'(fifo_count), 32'd0);
    check("t4_flushed_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_target_addr", mem_addr, 32'h200);
    check("t4_req", {31'd0, mem_req}, 32'd1);
    step();
    check("t4_first_pc", inst_pc, 32'h200);
    repeat (3) step();

    // Prefetch abort on 0x8 only.
    abort_en   = 1'b1;
    abort_addr = 32'h8;
    do_reset();
    repeat (3) step();
    check("t5_pc4", inst_pc, 32'h4);
    check("t5_abort4", {31'd0, inst_abort}, 32'd0);
    step();
    check("t5_pc8", inst_pc, 32'h8);
    check("t5_abort8", {31'd0, inst_abort}, 32'd1);
    step();
    check("t5_pcC", inst_pc, 32'hC);
    check("t5_abortC", {31'd0, inst_abort}, 32'd0);
    abort_en = 1'b0;
    step();

    // Redirect near the top of the address space wraps to zero.
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFB;
    step();
    branch_valid = 1'b0;
    check("t6_addr_f8", mem_addr, 32'hFFFF_FFF8);
    check("t6_valid_low", {31'd0, inst_valid}, 32'd0);
    step();
    check("t6_addr_fc", mem_addr, 32'hFFFF_FFFC);
    check("t6_pc_f8", inst_pc, 32'hFFFF_FFF8);
    step();
    check("t6_addr_wrap", mem_addr, 32'h0);
    check("t6_pc_fc", inst_pc, 32'hFFFF_FFFC);
    step();
    check("t6_pc_0", inst_pc, 32'h0);
    check("t6_data_0", inst_data, 32'hA5A5_A5A5);

    // Asynchronous reset in the middle of a pending request.
    mem_lat    = 3;
    inst_ready = 1'b0;
    do_reset();
    repeat (10) step();
    check("t7_pre_req", {31'd0, mem_req}, 32'd1);
    check("t7_pre_valid", {31'd0, inst_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_req", {31'd0, mem_req}, 32'd0);
    check("t7_async_valid", {31'd0, inst_valid}, 32'd0);
    check("t7_async_count", 32'(fifo_count), 32'd0);
    repeat (2) step();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    mem_lat    = 0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
